regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the pipelined MIPS core; next generation of the single-write, dual-read register file. It adds configurable width, depth and port counts, a write-port priority rule, a per-register scoreboard of pending writes for hazard detection, and a sequenced clear after reset so the array can map to RAM. It sits between decode (reads, reservations) and writeback (writes).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_scoreboard.sv | 45 ++++
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, state encoding and sizing helper for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of regfile_mp. The slave side is the register file.
interface regfile_mp_if #(
    parameter int DATA_W = regfile_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1
) ();
    import regfile_pkg::*;

    logic [NRD*ADDR_W-1:0] ra;
    logic [NRD*DATA_W-1:0] rd;
    logic [NRD-1:0]        rbusy;
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] wa;
    logic [NWR*DATA_W-1:0] wd;
    logic                  resv_en;
    logic [ADDR_W-1:0]     resv_addr;
    logic                  ready;
    rf_state_t             dbg_state;

    // No handshake: every input is sampled at each rising edge while ready is high.
    modport slave (
        input  ra, we, wa, wd, resv_en, resv_addr,
        output rd, rbusy, ready, dbg_state
    );

    modport master (
        output ra, we, wa, wd, resv_en, resv_addr,
        input  rd, rbusy, ready, dbg_state
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: writes clear, reservations set (set wins), register 0 never busy.
module regfile_scoreboard #(
    parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic [NWR-1:0]        clr_en,
    input  logic [NWR*ADDR_W-1:0] clr_addr,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD-1:0]        rbusy
);
    import regfile_pkg::*;

    localparam int NREGS = nregs(ADDR_W);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int k = 0; k < NWR; k++) begin
            if (clr_en[k]) busy_d[clr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
        end
        // Applied after the clears so a same-cycle reservation keeps the bit set.
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        rbusy = '0;
        for (int p = 0; p < NRD; p++) begin
            rbusy[p] = busy_q[ra[p*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with post-reset sequenced clear and pending-write scoreboard.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = 2,
    parameter int NWR    = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int NREGS = nregs(ADDR_W);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_we;
    logic              run;
    logic [NWR-1:0]    wr_ok;
    logic              resv_ok;

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = !rst;
                if (idx_q == ADDR_W'(NREGS - 1)) state_d = RUN;
                else                             idx_d   = idx_q + 1'b1;
            end
            RUN: ;
            default: state_d = CLEAR;
        endcase
    end

    assign run           = (state_q == RUN);
    assign bus.ready     = run;
    assign bus.dbg_state = state_q;

    always_comb begin
        wr_ok = '0;
        for (int k = 0; k < NWR; k++) begin
            wr_ok[k] = run && bus.we[k] && (bus.wa[k*ADDR_W +: ADDR_W] != '0);
        end
    end

    assign resv_ok = run && bus.resv_en && (bus.resv_addr != '0);

    // Higher-numbered write ports are later in the loop, so port 1 wins on a shared address.
    always_ff @(posedge clk) begin
        if (clr_we) mem[idx_q] <= '0;
        for (int k = 0; k < NWR; k++) begin
            if (wr_ok[k]) mem[bus.wa[k*ADDR_W +: ADDR_W]] <= bus.wd[k*DATA_W +: DATA_W];
        end
    end

    logic [NRD-1:0] sb_busy;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NRD    (NRD),
        .NWR    (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (resv_ok),
        .set_addr (bus.resv_addr),
        .clr_en   (wr_ok),
        .clr_addr (bus.wa),
        .ra       (bus.ra),
        .rbusy    (sb_busy)
    );

    logic [NRD*DATA_W-1:0] rd_flat;
    logic [NRD-1:0]        rbusy_flat;
    logic [ADDR_W-1:0]     ra_p;

    always_comb begin
        rd_flat    = '0;
        rbusy_flat = '0;
        ra_p       = '0;
        for (int p = 0; p < NRD; p++) begin
            ra_p = bus.ra[p*ADDR_W +: ADDR_W];
            if (run && (ra_p != '0)) begin
                rd_flat[p*DATA_W +: DATA_W] = mem[ra_p];
                rbusy_flat[p]               = sb_busy[p];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    if (wr_ok[k] && (bus.wa[k*ADDR_W +: ADDR_W] == ra_p)) begin
                        rd_flat[p*DATA_W +: DATA_W] = bus.wd[k*DATA_W +: DATA_W];
                        rbusy_flat[p]               = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.rd    = rd_flat;
    assign bus.rbusy = rbusy_flat;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (2 read ports, 2 write ports), hand-computed expectations.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .NWR(2)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .NWR(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we        = 2'b00;
    bus.wa        = '0;
    bus.wd        = '0;
    bus.resv_en   = 1'b0;
    bus.resv_addr = '0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.ra = {a1, a0};
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd0();
    return bus.rd[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] rd1();
    return bus.rd[2*DW-1:DW];
  endfunction

  logic [DW-1:0] exp_same;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.ra      = '0;
    idle();

    // reset state
    repeat (3) tick();
    set_ra(5'd7, 5'd31);
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_rbusy", {30'd0, bus.rbusy}, 32'd0);
    check("rst_rd", rd0() | rd1(), 32'd0);
    check("rst_state", {31'd0, bus.dbg_state}, {31'd0, CLEAR});

    // clear sequence with a write attempt that must be dropped
    rst       = 1'b0;
    bus.we    = 2'b01;
    bus.wa    = {5'd0, 5'd5};
    bus.wd    = {32'd0, 32'h0000_DEAD};
    bus.resv_en   = 1'b1;
    bus.resv_addr = 5'd5;
    set_ra(5'd5, 5'd5);
    for (int c = 0; c < 32; c++) begin
      check("clear_ready", {31'd0, bus.ready}, 32'd0);
      if (c == 0 || c == 31) check("clear_rd", rd0(), 32'd0);
      tick();
    end
    idle();
    set_ra(5'd5, 5'd5);
    check("ready_at_32", {31'd0, bus.ready}, 32'd1);
    check("state_run", {31'd0, bus.dbg_state}, {31'd0, RUN});
    check("reg5_dropped", rd0(), 32'd0);
    check("resv_dropped", {31'd0, bus.rbusy[0]}, 32'd0);

    for (int i = 0; i < 32; i++) begin
      set_ra(AW'(i), AW'(31 - i));
      check("all_zero", rd0() | rd1(), 32'd0);
    end

    // basic write/read
    bus.we = 2'b01;
    bus.wa = {5'd0, 5'd7};
    bus.wd = {32'd0, 32'h1234_5678};
    set_ra(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h1234_5678;
`else
    exp_same = 32'd0;
`endif
    check("w7_same_cycle", rd0(), exp_same);
    tick();
    idle();
    set_ra(5'd7, 5'd7);
    check("w7_port0", rd0(), 32'h1234_5678);
    check("w7_port1", rd1(), 32'h1234_5678);

    bus.we = 2'b10;
    bus.wa = {5'd0, 5'd0};
    bus.wd = {32'hFFFF_FFFF, 32'd0};
    tick();
    idle();
    set_ra(5'd0, 5'd0);
    check("r0_port0", rd0(), 32'd0);
    check("r0_port1", rd1(), 32'd0);

    // dual-write conflict and independent dual write
    bus.we = 2'b11;
    bus.wa = {5'd9, 5'd9};
    bus.wd = {32'hB, 32'hA};
    tick();
    bus.wa = {5'd11, 5'd10};
    bus.wd = {32'h11, 32'h10};
    tick();
    idle();
    set_ra(5'd9, 5'd10);
    check("conflict_port1_wins", rd0(), 32'hB);
    check("dual_w10", rd1(), 32'h10);
    set_ra(5'd11, 5'd7);
    check("dual_w11", rd0(), 32'h11);
    check("w7_kept", rd1(), 32'h1234_5678);

    // scoreboard
    bus.resv_en   = 1'b1;
    bus.resv_addr = 5'd3;
    set_ra(5'd3, 5'd2);
    check("resv_not_yet", {31'd0, bus.rbusy[0]}, 32'd0);
    tick();
    idle();
    set_ra(5'd3, 5'd2);
    check("resv_busy", {31'd0, bus.rbusy[0]}, 32'd1);
    check("other_idle", {31'd0, bus.rbusy[1]}, 32'd0);

    bus.we = 2'b01;
    bus.wa = {5'd0, 5'd3};
    bus.wd = {32'd0, 32'h33};
    tick();
    idle();
    set_ra(5'd3, 5'd3);
    check("write_clears", {30'd0, bus.rbusy}, 32'd0);

    bus.we        = 2'b10;
    bus.wa        = {5'd3, 5'd0};
    bus.wd        = {32'h34, 32'd0};
    bus.resv_en   = 1'b1;
    bus.resv_addr = 5'd3;
    tick();
    idle();
    set_ra(5'd3, 5'd0);
    check("resv_beats_write", {31'd0, bus.rbusy[0]}, 32'd1);
    check("resv_write_data", rd0(), 32'h34);

    bus.resv_en   = 1'b1;
    bus.resv_addr = 5'd0;
    tick();
    idle();
    set_ra(5'd0, 5'd3);
    check("r0_never_busy", {30'd0, bus.rbusy}, 32'b10);

    // same-cycle read of a register being written
    bus.we = 2'b01;
    bus.wa = {5'd0, 5'd4};
    bus.wd = {32'd0, 32'h55};
    set_ra(5'd4, 5'd9);
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h55;
`else
    exp_same = 32'd0;
`endif
    check("bypass_same_cycle", rd0(), exp_same);
    tick();
    idle();
    set_ra(5'd4, 5'd9);
    check("w4_next_cycle", rd0(), 32'h55);

    // reserve reg 6, then reset mid-clear; busy and data must be wiped
    bus.resv_en   = 1'b1;
    bus.resv_addr = 5'd6;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    set_ra(5'd6, 5'd7);
    check("midclear_ready", {31'd0, bus.ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.resv_en   = 1'b1;
    bus.resv_addr = 5'd8;
    for (int c = 0; c < 32; c++) begin
      if (c == 0 || c == 31) check("reclear_ready", {31'd0, bus.ready}, 32'd0);
      tick();
    end
    idle();
    set_ra(5'd6, 5'd8);
    check("reclear_ready_32", {31'd0, bus.ready}, 32'd1);
    check("reclear_busy_wiped", {30'd0, bus.rbusy}, 32'd0);
    set_ra(5'd7, 5'd4);
    check("reclear_data_wiped", rd0() | rd1(), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    miscompares++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "timeout");
  end

endmodule
